// File: rtl/arb_rr_n.sv
// arb_rr_n: N-requester bus arbiter with fixed-priority or round-robin
// selection, a bounded hold time with preemption and zero-bubble handoff.
// Outputs are decoded purely from registered state, so they only move on
// clock edges and grant can never be two-hot.
module arb_rr_n #(
    parameter int N        = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 4,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   request,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           preempt
);

    // A hold limit of 0 means unlimited; keep the counter one bit wide then.
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] owner_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [HW-1:0]  hcnt_q;
    logic [HW-1:0]  hcnt_d;
    logic           preempt_q;
    logic           preempt_d;

    logic [N-1:0]   owner_bit;
    logic [N-1:0]   others;
    logic [N-1:0]   cand;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] next_ptr;
    logic           found;
    logic           at_limit;

    // Candidate mask: everyone when idle, everyone except the owner otherwise.
    always_comb begin
        owner_bit = N'(1) << owner_q;
        others    = request & ~owner_bit;
        cand      = (state_q == IDLE) ? request : others;
        at_limit  = (MAX_HOLD != 0) && (hcnt_q == HW'(MAX_HOLD));
    end

    // Winner search: circular scan from ptr (round-robin) or from 0 (fixed).
    always_comb begin
        int start;
        int idx;
        winner = '0;
        found  = 1'b0;
        start  = (MODE == 0) ? 0 : int'(ptr_q);
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (start + i) % N;
            if (!found && cand[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
        next_ptr = IDW'((int'(winner) + 1) % N);
    end

    // State register: owner, pointer, hold counter and the preempt pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            preempt_q <= preempt_d;
        end
    end

    // Next-state logic: fresh grant, handoff, preemption or keep/increment.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWNED;
                    owner_d = winner;
                    hcnt_d  = HW'(1);
                    if (MODE != 0) ptr_d = next_ptr;
                end
            end
            OWNED: begin
                if (!request[owner_q]) begin
                    if (found) begin
                        owner_d = winner;
                        hcnt_d  = HW'(1);
                        if (MODE != 0) ptr_d = next_ptr;
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                        hcnt_d  = '0;
                    end
                end else if (at_limit && found) begin
                    owner_d   = winner;
                    hcnt_d    = HW'(1);
                    preempt_d = 1'b1;
                    if (MODE != 0) ptr_d = next_ptr;
                end else if ((MAX_HOLD != 0) && !at_limit) begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        grant_valid = (state_q == OWNED);
        grant       = grant_valid ? owner_bit : '0;
        grant_id    = grant_valid ? owner_q : '0;
        preempt     = preempt_q;
    end

endmodule

// File: tb/tb_arb_rr_n.sv
// tb_arb_rr_n: four arbiter instances with different MODE/MAX_HOLD settings,
// a cycle-level reference model and directed scenarios with literal checks.
//   dut 0: MODE=1 MAX_HOLD=4   dut 1: MODE=1 MAX_HOLD=0
//   dut 2: MODE=0 MAX_HOLD=0   dut 3: MODE=1 MAX_HOLD=2
module tb_arb_rr_n;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req  [4];
    logic [3:0] gnt  [4];
    logic       gv   [4];
    logic [1:0] gid  [4];
    logic       pre  [4];

    int n_checks = 0;
    int n_fail   = 0;

    int m_owner [4];
    int m_ptr   [4];
    int m_held  [4];
    bit m_valid [4];
    bit m_pre   [4];
    bit armed = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        arb_rr_n #(
            .N(N),
            .MODE((g == 2) ? 0 : 1),
            .MAX_HOLD((g == 0) ? 4 : ((g == 3) ? 2 : 0))
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .request(req[g]),
            .grant(gnt[g]),
            .grant_valid(gv[g]),
            .grant_id(gid[g]),
            .preempt(pre[g])
        );
    end

    function automatic int mode_of(int k);
        return (k == 2) ? 0 : 1;
    endfunction

    function automatic int hold_of(int k);
        return (k == 0) ? 4 : ((k == 3) ? 2 : 0);
    endfunction

    // Lowest set index (fixed) or first set index from ptr going round.
    function automatic int pick(int mode, int ptr, logic [3:0] mask);
        int start;
        start = (mode == 0) ? 0 : ptr;
        for (int i = 0; i < N; i++) begin
            if (mask[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one step per rising edge for every instance.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            int         owner;
            int         ptr;
            int         held;
            int         w;
            bit         valid;
            bit         pflag;
            logic [3:0] r;
            logic [3:0] oth;
            owner = m_owner[k];
            ptr   = m_ptr[k];
            held  = m_held[k];
            valid = m_valid[k];
            pflag = 1'b0;
            r     = req[k];
            w     = -1;
            if (rst) begin
                owner = 0; ptr = 0; held = 0; valid = 1'b0;
            end else if (!valid) begin
                w = pick(mode_of(k), ptr, r);
            end else begin
                oth = r & ~(4'b0001 << owner);
                if (!r[owner]) begin
                    w = pick(mode_of(k), ptr, oth);
                    if (w < 0) begin
                        valid = 1'b0; owner = 0; held = 0;
                    end
                end else if (hold_of(k) != 0 && held >= hold_of(k) && oth != 4'b0) begin
                    w = pick(mode_of(k), ptr, oth);
                    pflag = 1'b1;
                end else begin
                    held = held + 1;
                end
            end
            if (w >= 0) begin
                valid = 1'b1;
                owner = w;
                held  = 1;
                if (mode_of(k) != 0) ptr = (w + 1) % N;
            end
            m_owner[k] <= owner;
            m_ptr[k]   <= ptr;
            m_held[k]  <= held;
            m_valid[k] <= valid;
            m_pre[k]   <= pflag;
        end
        if (rst) armed <= 1'b1;
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 4; k++) begin
                int eg;
                eg = m_valid[k] ? (1 << m_owner[k]) : 0;
                checkOutput($sformatf("model_grant[%0d]", k), int'(gnt[k]), eg);
                checkOutput($sformatf("model_valid[%0d]", k), int'(gv[k]), int'(m_valid[k]));
                checkOutput($sformatf("model_id[%0d]", k), int'(gid[k]), m_valid[k] ? m_owner[k] : 0);
                checkOutput($sformatf("model_preempt[%0d]", k), int'(pre[k]), int'(m_pre[k]));
            end
        end
    end

    // Drive one instance's request, then advance to just after the next edge.
    task automatic applyStimulus(input int k, input logic [3:0] val);
        req[k] = val;
        @(posedge clk);
        #2;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) req[k] = 4'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_grant", int'(gnt[0]), 0);
        checkOutput("reset_id", int'(gid[0]), 0);
        rst = 1'b0;

        // Reset mid-grant on instance 0
        applyStimulus(0, 4'b0100);
        checkOutput("rst_pre_grant", int'(gnt[0]), 4'b0100);
        checkOutput("rst_pre_id", int'(gid[0]), 2);
        applyStimulus(0, 4'b0100);
        applyReset();
        checkOutput("rst_mid_grant", int'(gnt[0]), 0);
        checkOutput("rst_mid_valid", int'(gv[0]), 0);
        checkOutput("rst_mid_id", int'(gid[0]), 0);
        checkOutput("rst_mid_preempt", int'(pre[0]), 0);
        applyStimulus(0, 4'b1111);
        checkOutput("rst_after_grant", int'(gnt[0]), 4'b0001);
        applyStimulus(0, 4'b0000);
        checkOutput("rst_idle", int'(gnt[0]), 0);

        // Preemption after four cycles on instance 0
        applyStimulus(0, 4'b0001);
        checkOutput("pre_first", int'(gnt[0]), 4'b0001);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 4'b0101);
            checkOutput($sformatf("pre_hold%0d", i + 2), int'(gnt[0]), 4'b0001);
        end
        applyStimulus(0, 4'b0101);
        checkOutput("pre_takeover", int'(gnt[0]), 4'b0100);
        checkOutput("pre_pulse", int'(pre[0]), 1);
        applyStimulus(0, 4'b0101);
        checkOutput("pre_keep", int'(gnt[0]), 4'b0100);
        checkOutput("pre_pulse_end", int'(pre[0]), 0);
        applyStimulus(0, 4'b0001);
        checkOutput("pre_regain", int'(gnt[0]), 4'b0001);
        applyStimulus(0, 4'b0000);

        // Lone owner never preempted on instance 0
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 4'b1000);
            checkOutput("lone_grant", int'(gnt[0]), 4'b1000);
            checkOutput("lone_preempt", int'(pre[0]), 0);
        end
        applyStimulus(0, 4'b0000);

        // Round-robin rotation without bubbles on instance 1
        applyStimulus(1, 4'b1111);
        checkOutput("rr_0", int'(gnt[1]), 4'b0001);
        applyStimulus(1, 4'b1110);
        checkOutput("rr_1", int'(gnt[1]), 4'b0010);
        applyStimulus(1, 4'b1101);
        checkOutput("rr_2", int'(gnt[1]), 4'b0100);
        applyStimulus(1, 4'b1011);
        checkOutput("rr_3", int'(gnt[1]), 4'b1000);
        checkOutput("rr_3_id", int'(gid[1]), 3);
        applyStimulus(1, 4'b0111);
        checkOutput("rr_wrap", int'(gnt[1]), 4'b0001);
        applyStimulus(1, 4'b0000);
        checkOutput("rr_idle", int'(gv[1]), 0);

        // Fixed priority on instance 2
        applyStimulus(2, 4'b1010);
        checkOutput("fp_low", int'(gnt[2]), 4'b0010);
        applyStimulus(2, 4'b1000);
        checkOutput("fp_handoff", int'(gnt[2]), 4'b1000);
        applyStimulus(2, 4'b1010);
        checkOutput("fp_keep1", int'(gnt[2]), 4'b1000);
        applyStimulus(2, 4'b1010);
        checkOutput("fp_keep2", int'(gnt[2]), 4'b1000);
        applyStimulus(2, 4'b0000);

        // Drop at hold limit, then a real preemption, on instance 3
        applyStimulus(3, 4'b0010);
        checkOutput("dl_first", int'(gnt[3]), 4'b0010);
        applyStimulus(3, 4'b1010);
        checkOutput("dl_limit", int'(gnt[3]), 4'b0010);
        applyStimulus(3, 4'b1000);
        checkOutput("dl_handoff", int'(gnt[3]), 4'b1000);
        checkOutput("dl_no_preempt", int'(pre[3]), 0);
        applyStimulus(3, 4'b1010);
        checkOutput("dl_hold2", int'(gnt[3]), 4'b1000);
        applyStimulus(3, 4'b1010);
        checkOutput("dl_preempt_grant", int'(gnt[3]), 4'b0010);
        checkOutput("dl_preempt_pulse", int'(pre[3]), 1);
        applyStimulus(3, 4'b0000);
        applyStimulus(3, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
